cache_line_arbiter: RTL and testbench
=====================================

# cache_line_arbiter

Arbitrates a single cacheline-wide physical memory port between the instruction-cache miss port and the data-cache miss/writeback port. It sits between both L1 caches and the cacheline adaptor. It serialises line transactions, so one transaction is in flight at a time. It applies round-robin priority when both caches miss in the same cycle and keeps per-requester grant and wait counters for stall analysis.

## Interface
Parameters:
- ADDR_W, 32, physical address width (line-aligned addresses; low 5 bits passed through unchanged)
- LINE_W, 256, cacheline width in bits
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset: state is cleared on the rising edge of clk when rst==0
- i_read  in  1  icache line fill request, held until i_resp
- i_addr  in  ADDR_W  icache fill address
- i_rdata  out  LINE_W  fill data to icache
- i_resp  out  1  one-cycle completion pulse to icache
- d_read  in  1  dcache line fill request, held until d_resp
- d_write  in  1  dcache writeback request, held until d_resp; never asserted together with d_read
- d_addr  in  ADDR_W  dcache address
- d_wdata  in  LINE_W  writeback data
- d_rdata  out  LINE_W  fill data to dcache
- d_resp  out  1  one-cycle completion pulse to dcache
- mem_read  out  1  read to the cacheline adaptor
- mem_write  out  1  write to the cacheline adaptor
- mem_addr  out  ADDR_W  address to the adaptor
- mem_wdata  out  LINE_W  write data to the adaptor
- mem_rdata  in  LINE_W  read data from the adaptor
- mem_resp  in  1  adaptor completion, one cycle
- i_grant_cnt  out  CNT_W  completed icache transactions
- d_grant_cnt  out  CNT_W  completed dcache transactions
- i_wait_cnt  out  CNT_W  cycles icache request pending but not granted
- d_wait_cnt  out  CNT_W  cycles dcache request pending but not granted

## Operation
- The FSM has four states: IDLE, SERVE_I, SERVE_D and DONE.
- In IDLE, with `d_req = d_read|d_write` and `i_req = i_read`:
  - Only one request pending: go to that SERVE state.
  - Both pending: grant the requester opposite to `last_grant`.
  - Neither pending: stay in IDLE.
- On entering a SERVE state, update `last_grant`. Reset value is INST, so the first tie goes to D.
- SERVE_I:
  - Drive mem_read=1 and mem_addr=i_addr.
  - On mem_resp, drive i_resp=1 and i_rdata=mem_rdata in the same cycle, and go to DONE.
- SERVE_D:
  - Drive mem_read=d_read, mem_write=d_write, mem_addr=d_addr and mem_wdata=d_wdata.
  - On mem_resp, drive d_resp=1 and d_rdata=mem_rdata, and go to DONE.
- DONE:
  - Turnaround cycle: no mem command and no resp.
  - Always go to IDLE. This guarantees a request still asserted in the resp cycle is not re-granted.
- Outside their SERVE state, mem_read, mem_write, i_resp and d_resp are 0.
- rdata outputs pass mem_rdata through; they are valid only when the matching resp is high.
- Counters:
  - A grant counter increments on its resp pulse.
  - A wait counter increments in every cycle where that requester's req=1 and the FSM is not in its SERVE state. DONE and IDLE cycles therefore count.
  - All counters wrap modulo 2^CNT_W.
- Requester protocol violations are not recovered:
  - Dropping a request mid-SERVE leaves the arbiter waiting for mem_resp.
  - The arbiter never aborts a memory transaction.

## Timing
- Reset (rst==0 at an edge):
  - state=IDLE, last_grant=INST, all counters 0.
  - mem_read, mem_write, i_resp and d_resp are 0 from that edge on.
  - Reset mid-SERVE abandons the transaction. The adaptor is required to be reset in the same cycle.
- Grant latency: a request seen in IDLE at edge N drives the mem command during cycle N+1.
- Total cycles from request to resp: 1 + adaptor latency. The resp cycle is the mem_resp cycle.
- Back-to-back minimum spacing: resp, DONE, IDLE, next SERVE. That is 3 cycles from one resp to the next mem command.
- mem_addr, mem_wdata, mem_read and mem_write are stable for the whole SERVE state while requester inputs are held.
- mem_resp arriving in IDLE or DONE is ignored.

## Test plan
- **Icache only:** i_read=1, i_addr=0x0000_0060; adaptor responds 4 cycles after mem_read with 0xAB..AB.
  - Expected: mem_read=1 and mem_addr=0x60 in the cycle after the request.
  - Expected: i_resp for one cycle with i_rdata=0xAB..AB, then DONE, then IDLE; i_grant_cnt=1.
- **Simultaneous after reset:** i_read and d_read asserted together.
  - Expected: D is served first; i_wait_cnt counts every cycle until SERVE_I.
  - Expected: I is served second; no mem command appears in the DONE cycle.
- **Round robin:** both requesters re-request continuously for 4 transactions.
  - Expected: grant order D, I, D, I; both grant counts equal 2.
- **Writeback:** d_write=1, d_addr=0x8000_0020, d_wdata=0x5A..5A.
  - Expected: mem_write=1 with that address and data, mem_read=0.
  - Expected: d_resp on mem_resp; no i_resp.
- **Reset mid-SERVE_D:** rst=0 for one cycle while the transaction is in flight.
  - Expected: next cycle state=IDLE, mem_write=0, all counters 0, last_grant=INST.
  - Expected: a stale mem_resp after reset produces no resp.
- **Counter wrap:** force d_wait_cnt to 2^CNT_W-1 and hold d_read pending for one cycle.
  - Expected: d_wait_cnt reads 0.

Source files
------------

// File: rtl/cache_line_arbiter.sv
// cache_line_arbiter: shares one cacheline-wide memory port between
// the icache miss port and the dcache miss/writeback port.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-low reset
//   i_read/i_addr       icache fill request (held until i_resp)
//   i_rdata/i_resp      icache fill data and one-cycle completion pulse
//   d_read/d_write      dcache fill / writeback request (held until d_resp)
//   d_addr/d_wdata      dcache address and writeback data
//   d_rdata/d_resp      dcache fill data and one-cycle completion pulse
//   mem_*               command/response to the cacheline adaptor
//   *_grant_cnt         completed transactions per requester
//   *_wait_cnt          cycles a request was pending but not being served
module cache_line_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic [CNT_W-1:0]  i_grant_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt,
  output logic [CNT_W-1:0]  i_wait_cnt,
  output logic [CNT_W-1:0]  d_wait_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } grant_t;

  state_t r_state;
  state_t w_next;
  grant_t r_last;

  logic w_i_req;
  logic w_d_req;

  logic [CNT_W-1:0] r_i_grant;
  logic [CNT_W-1:0] r_d_grant;
  logic [CNT_W-1:0] r_i_wait;
  logic [CNT_W-1:0] r_d_wait;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

  // Fill data is a straight pass-through; only
  // meaningful while the matching resp is high.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  always_comb begin
    w_next    = r_state;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_i_req && w_d_req) begin
          // Tie: the side that did not win last time.
          if (r_last == INST) w_next = SERVE_D;
          else                w_next = SERVE_I;
        end else if (w_d_req) begin
          w_next = SERVE_D;
        end else if (w_i_req) begin
          w_next = SERVE_I;
        end
      end
      SERVE_I: begin
        mem_read = 1'b1;
        mem_addr = i_addr;
        if (mem_resp) begin
          i_resp = 1'b1;
          w_next = DONE;
        end
      end
      SERVE_D: begin
        mem_read  = d_read;
        mem_write = d_write;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        if (mem_resp) begin
          d_resp = 1'b1;
          w_next = DONE;
        end
      end
      DONE: begin
        // Turnaround: a request still held in the
        // resp cycle must not be granted again.
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_last  <= INST;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == SERVE_I)
        r_last <= INST;
      if (r_state == IDLE && w_next == SERVE_D)
        r_last <= DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_i_grant <= '0;
      r_d_grant <= '0;
      r_i_wait  <= '0;
      r_d_wait  <= '0;
    end else begin
      if (i_resp)
        r_i_grant <= r_i_grant + CNT_W'(1);
      if (d_resp)
        r_d_grant <= r_d_grant + CNT_W'(1);
      // IDLE and DONE cycles count as waiting too.
      if (w_i_req && r_state != SERVE_I)
        r_i_wait <= r_i_wait + CNT_W'(1);
      if (w_d_req && r_state != SERVE_D)
        r_d_wait <= r_d_wait + CNT_W'(1);
    end
  end

  assign i_grant_cnt = r_i_grant;
  assign d_grant_cnt = r_d_grant;
  assign i_wait_cnt  = r_i_wait;
  assign d_wait_cnt  = r_d_wait;

endmodule

// File: tb/tb_cache_line_arbiter.sv
// tb_cache_line_arbiter: random requesters and adaptor checked
// against a transaction-level model of the arbiter.
module tb_cache_line_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
  localparam int CW = 8;
  localparam int NCYC = 4000;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;
  logic [CW-1:0] i_grant_cnt;
  logic [CW-1:0] d_grant_cnt;
  logic [CW-1:0] i_wait_cnt;
  logic [CW-1:0] d_wait_cnt;

  always #5 clk = ~clk;

  cache_line_arbiter #(
    .ADDR_W(AW),
    .LINE_W(LW),
    .CNT_W (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_read     (i_read),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp),
    .i_grant_cnt(i_grant_cnt),
    .d_grant_cnt(d_grant_cnt),
    .i_wait_cnt (i_wait_cnt),
    .d_wait_cnt (d_wait_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [LW-1:0] got,
                       input logic [LW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  function automatic logic [LW-1:0] rline();
    logic [LW-1:0] r;
    for (int k = 0; k < LW / 32; k++)
      r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Model: who owns the port (0 none, 1 icache, 2 dcache),
  // a one-cycle cooldown after each completion, who won
  // the last grant, and the adaptor's remaining delay.
  int            owner;
  bit            cool;
  bit            last_d;
  int            lat;
  logic [CW-1:0] m_ig, m_dg, m_iw, m_dw;
  bit            i_fin, d_fin, drop;
  bit            e_mr, e_mw, e_ir, e_dr, wr, ireq, dreq;

  initial begin
    rst = 1'b0;
    i_read = 1'b0; i_addr = '0;
    d_read = 1'b0; d_write = 1'b0;
    d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0;
    owner = 0; cool = 1'b0; last_d = 1'b0; lat = 0;
    m_ig = '0; m_dg = '0; m_iw = '0; m_dw = '0;
    i_fin = 1'b0; d_fin = 1'b0; drop = 1'b0;

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      if (drop) begin
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        drop = 1'b0;
      end
      if (i_fin) begin i_read = 1'b0; i_fin = 1'b0; end
      if (d_fin) begin
        d_read = 1'b0; d_write = 1'b0; d_fin = 1'b0;
      end

      rst = (c < 2 || c == 2500 ||
             $urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;

      if (!i_read && (c == 2 || $urandom_range(0, 3) == 0)) begin
        i_read = 1'b1;
        i_addr = $urandom;
      end
      if (!(d_read || d_write) &&
          (c == 2 || $urandom_range(0, 3) == 0)) begin
        wr = (c != 2) && ($urandom_range(0, 2) == 0);
        d_read  = !wr;
        d_write = wr;
        d_addr  = $urandom;
        d_wdata = rline();
      end

      mem_rdata = rline();
      if (owner != 0) mem_resp = (lat == 0);
      else            mem_resp = ($urandom_range(0, 5) == 0);

      #1;
      check("i_grant_cnt", i_grant_cnt, m_ig);
      check("d_grant_cnt", d_grant_cnt, m_dg);
      check("i_wait_cnt",  i_wait_cnt,  m_iw);
      check("d_wait_cnt",  d_wait_cnt,  m_dw);

      e_mr = (owner == 1) || (owner == 2 && d_read);
      e_mw = (owner == 2) && d_write;
      e_ir = (owner == 1) && mem_resp;
      e_dr = (owner == 2) && mem_resp;
      check("mem_read",  mem_read,  e_mr);
      check("mem_write", mem_write, e_mw);
      check("i_resp",    i_resp,    e_ir);
      check("d_resp",    d_resp,    e_dr);
      if (owner == 1) check("mem_addr_i", mem_addr, i_addr);
      if (owner == 2) check("mem_addr_d", mem_addr, d_addr);
      if (owner == 2 && d_write)
        check("mem_wdata", mem_wdata, d_wdata);
      if (e_ir) check("i_rdata", i_rdata, mem_rdata);
      if (e_dr) check("d_rdata", d_rdata, mem_rdata);

      ireq = i_read;
      dreq = d_read || d_write;
      if (!rst) begin
        owner = 0; cool = 1'b0; last_d = 1'b0;
        m_ig = '0; m_dg = '0; m_iw = '0; m_dw = '0;
        drop = 1'b1;
      end else begin
        if (ireq && owner != 1) m_iw = m_iw + 1'b1;
        if (dreq && owner != 2) m_dw = m_dw + 1'b1;
        if (e_ir) begin m_ig = m_ig + 1'b1; i_fin = 1'b1; end
        if (e_dr) begin m_dg = m_dg + 1'b1; d_fin = 1'b1; end
        if (owner != 0) begin
          if (mem_resp) begin owner = 0; cool = 1'b1; end
          else lat--;
        end else if (cool) begin
          cool = 1'b0;
        end else if (ireq || dreq) begin
          if (ireq && dreq) owner = last_d ? 1 : 2;
          else              owner = dreq ? 2 : 1;
          last_d = (owner == 2);
          lat = $urandom_range(0, 4);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
